// File: rtl/mult16_share_arb.sv
// ---------------------------------------------------------------------------
// mult16_share_arb
//
// Shares one external 16x16 signed multiplier among NREQ requesters.
// A round-robin arbiter grants at most one requester per cycle. The granted
// operands are registered onto the multiplier inputs. The requester ID
// travels down a tag pipeline whose length matches the multiplier latency.
// Each product is returned on a shared result bus, tagged with the ID of the
// requester that owns it.
//
// Parameters
//   NREQ    : number of requesters (2..8)
//   MUL_LAT : register stages inside the external multiplier (0..4)
//   IDW     : result ID width, clog2(NREQ)
//
// Ports
//   sys_clk   in   clock, rising edge
//   sys_rst   in   synchronous active-high reset
//   hold      in   blocks new grants; in-flight work still drains
//   req_vld   in   [NREQ]      per-requester request valid
//   req_a     in   [NREQ*16]   multiplicands, requester i at [16i+15:16i]
//   req_b     in   [NREQ*16]   multipliers, same packing
//   req_rdy   out  [NREQ]      one-hot grant (combinational)
//   mul_a     out  [16]        registered operand A to the multiplier
//   mul_b     out  [16]        registered operand B to the multiplier
//   mul_vld   out              qualifies mul_a/mul_b
//   mul_p     in   [32]        product, valid MUL_LAT cycles after mul_vld
//   res_vld   out              single-cycle result strobe
//   res_id    out  [IDW]       owner of the result
//   res_p     out  [32]        registered product
//   inflight  out  [3]         accepted operations not yet returned
// ---------------------------------------------------------------------------
module mult16_share_arb #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [NREQ-1:0]      req_rdy,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    output logic                 mul_vld,
    input  logic [31:0]          mul_p,
    output logic                 res_vld,
    output logic [IDW-1:0]       res_id,
    output logic [31:0]          res_p,
    output logic [2:0]           inflight
);

    // Unpacked per-requester operand views.
    logic [15:0] a_arr [NREQ];
    logic [15:0] b_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[16*gi +: 16];
            assign b_arr[gi] = req_b[16*gi +: 16];
        end
    endgenerate

    logic [IDW-1:0]  ptr_reg;
    logic [IDW-1:0]  ptr_next;
    logic [NREQ-1:0] grant_next;
    logic [IDW-1:0]  grant_idx;
    logic            xfer;

    logic [15:0]     mul_a_reg;
    logic [15:0]     mul_b_reg;
    logic            mul_vld_reg;

    logic [MUL_LAT:0] tag_vld_reg;
    logic [IDW-1:0]   tag_id_reg [MUL_LAT+1];

    logic            res_vld_reg;
    logic [IDW-1:0]  res_id_reg;
    logic [31:0]     res_p_reg;
    logic [2:0]      inflight_reg;

    // Round-robin search. The first pass looks at indices at or above the
    // pointer. The second pass covers the wrapped part below the pointer; it
    // only wins if the first pass found nothing.
    always_comb begin
        grant_next = '0;
        grant_idx  = '0;
        xfer       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!xfer && req_vld[i] && (i >= int'(ptr_reg))) begin
                xfer          = 1'b1;
                grant_next[i] = 1'b1;
                grant_idx     = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!xfer && req_vld[i]) begin
                xfer          = 1'b1;
                grant_next[i] = 1'b1;
                grant_idx     = IDW'(i);
            end
        end
        if (hold || sys_rst) begin
            grant_next = '0;
            xfer       = 1'b0;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (xfer) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + IDW'(1);
            end
        end
    end

    // Pointer and registered multiplier operands. The operands keep their
    // last value on idle cycles; only mul_vld drops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ptr_reg     <= '0;
            mul_a_reg   <= '0;
            mul_b_reg   <= '0;
            mul_vld_reg <= 1'b0;
        end else begin
            ptr_reg     <= ptr_next;
            mul_vld_reg <= xfer;
            if (xfer) begin
                mul_a_reg <= a_arr[grant_idx];
                mul_b_reg <= b_arr[grant_idx];
            end
        end
    end

    // Tag pipeline. Stage 0 is loaded together with mul_vld. Stage MUL_LAT
    // therefore lines up with the cycle in which mul_p is valid.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tag_vld_reg <= '0;
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_id_reg[s] <= '0;
            end
        end else begin
            tag_vld_reg[0] <= xfer;
            tag_id_reg[0]  <= grant_idx;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_vld_reg[s] <= tag_vld_reg[s-1];
                tag_id_reg[s]  <= tag_id_reg[s-1];
            end
        end
    end

    // Result capture and occupancy count.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            res_vld_reg  <= 1'b0;
            res_id_reg   <= '0;
            res_p_reg    <= '0;
            inflight_reg <= '0;
        end else begin
            res_vld_reg <= tag_vld_reg[MUL_LAT];
            if (tag_vld_reg[MUL_LAT]) begin
                res_id_reg <= tag_id_reg[MUL_LAT];
                res_p_reg  <= mul_p;
            end
            case ({xfer, res_vld_reg})
                2'b10:   inflight_reg <= inflight_reg + 3'd1;
                2'b01:   inflight_reg <= inflight_reg - 3'd1;
                default: inflight_reg <= inflight_reg;
            endcase
        end
    end

    assign req_rdy  = grant_next;
    assign mul_a    = mul_a_reg;
    assign mul_b    = mul_b_reg;
    assign mul_vld  = mul_vld_reg;
    assign res_vld  = res_vld_reg;
    assign res_id   = res_id_reg;
    assign res_p    = res_p_reg;
    assign inflight = inflight_reg;

endmodule

// File: tb/tb_mult16_share_arb.sv
// ---------------------------------------------------------------------------
// Testbench for mult16_share_arb (NREQ=4, MUL_LAT=2).
//
// The bench provides a pipelined multiplier model on mul_a/mul_b -> mul_p.
// A transaction-level reference model holds a round-robin pointer and a
// queue of expected results, each with its due cycle. A compare process
// checks every DUT output against that model on every cycle. Directed
// scenarios add literal expectations. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_mult16_share_arb;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic                hold    = 1'b0;
    logic [NREQ-1:0]     req_vld = '0;
    logic [NREQ*16-1:0]  req_a;
    logic [NREQ*16-1:0]  req_b;
    logic [NREQ-1:0]     req_rdy;
    logic [15:0]         mul_a;
    logic [15:0]         mul_b;
    logic                mul_vld;
    logic [31:0]         mul_p;
    logic                res_vld;
    logic [IDW-1:0]      res_id;
    logic [31:0]         res_p;
    logic [2:0]          inflight;

    logic [15:0] ra [NREQ];
    logic [15:0] rb [NREQ];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = ra[i];
            req_b[16*i +: 16] = rb[i];
        end
    end

    // External multiplier: MUL_LAT register stages.
    logic [31:0] p_pipe [MUL_LAT];
    initial for (int i = 0; i < MUL_LAT; i++) p_pipe[i] = '0;
    always @(posedge sys_clk) begin
        p_pipe[0] <= $signed(mul_a) * $signed(mul_b);
        for (int i = 1; i < MUL_LAT; i++) p_pipe[i] <= p_pipe[i-1];
    end
    assign mul_p = p_pipe[MUL_LAT-1];

    mult16_share_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .hold     (hold),
        .req_vld  (req_vld),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_rdy  (req_rdy),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_vld  (mul_vld),
        .mul_p    (mul_p),
        .res_vld  (res_vld),
        .res_id   (res_id),
        .res_p    (res_p),
        .inflight (inflight)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] p;
    } ent_t;

    ent_t            q[$];
    int              ptr_m = 0;
    logic            mv_m  = 1'b0;
    logic [15:0]     ma_m  = '0;
    logic [15:0]     mb_m  = '0;
    int              win;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_res;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    logic signed [31:0] prod;
    ent_t            e;

    always @(negedge sys_clk) begin
        if (check_en) begin
            win = -1;
            exp_rdy = '0;
            if (!sys_rst && !hold) begin
                for (int off = 0; off < NREQ; off++) begin
                    idx = (ptr_m + off) % NREQ;
                    if (win < 0 && req_vld[idx]) win = idx;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;

            chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
            chk("mul_vld", 32'(mul_vld), 32'(mv_m));
            chk("mul_a", 32'(mul_a), 32'(ma_m));
            chk("mul_b", 32'(mul_b), 32'(mb_m));

            exp_res = (q.size() > 0) && (q[0].due == cyc);
            chk("res_vld", 32'(res_vld), 32'(exp_res));
            chk("inflight", 32'(inflight), 32'(q.size()));
            if (exp_res) begin
                chk("res_id", 32'(res_id), 32'(q[0].id));
                chk("res_p", res_p, q[0].p);
                void'(q.pop_front());
            end

            // State for the coming edge.
            if (sys_rst) begin
                q.delete();
                ptr_m = 0;
                mv_m  = 1'b0;
                ma_m  = '0;
                mb_m  = '0;
            end else if (win >= 0) begin
                sa   = ra[win];
                sb   = rb[win];
                prod = sa * sb;
                e.due = cyc + 2 + MUL_LAT;
                e.id  = win;
                e.p   = prod;
                q.push_back(e);
                ptr_m = (win + 1) % NREQ;
                mv_m  = 1'b1;
                ma_m  = ra[win];
                mb_m  = rb[win];
            end else begin
                mv_m = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        req_vld = '0;
        hold    = 1'b0;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic drain(input int n);
        req_vld = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [31:0] ext_p [3];
    logic [15:0] ext_a [3];
    logic [15:0] ext_b [3];
    logic [NREQ-1:0] g;

    initial begin
        ext_a[0] = 16'h7FFF; ext_b[0] = 16'h8000; ext_p[0] = 32'hC0008000;
        ext_a[1] = 16'hFFFF; ext_b[1] = 16'hFFFF; ext_p[1] = 32'h00000001;
        ext_a[2] = 16'h0000; ext_b[2] = 16'h1234; ext_p[2] = 32'h00000000;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        sys_rst = 1'b1;
        tick();
        check_en = 1'b1;
        do_reset();

        // Single request: -3 * 5 from requester 0.
        ra[0] = 16'hFFFD; rb[0] = 16'd5; req_vld = 4'b0001;
        @(negedge sys_clk); chk("single_rdy", 32'(req_rdy), 32'h1);
        tick();
        req_vld = '0;
        @(negedge sys_clk); chk("single_mul_vld", 32'(mul_vld), 32'h1);
        tick(); tick(); tick();
        @(negedge sys_clk);
        chk("single_res_vld", 32'(res_vld), 32'h1);
        chk("single_res_id", 32'(res_id), 32'h0);
        chk("single_res_p", res_p, 32'hFFFFFFF1);
        drain(4);

        // All requesters contend.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16'(i + 1);
            rb[i] = 16'h0100;
        end
        req_vld = 4'b1111;
        for (int n = 0; n < 12; n++) begin
            @(negedge sys_clk);
            chk("contend_rdy", 32'(req_rdy), 32'(1 << (n % 4)));
            if (n >= 4) begin
                chk("contend_res_vld", 32'(res_vld), 32'h1);
                chk("contend_res_p", res_p, 32'(((n - 4) % 4 + 1) << 8));
            end
            tick();
        end
        @(negedge sys_clk); chk("contend_inflight", 32'(inflight), 32'd4);
        drain(6);

        // Pointer fairness and wrap.
        do_reset();
        req_vld = 4'b0100;
        @(negedge sys_clk); chk("wrap_rdy2", 32'(req_rdy), 32'h4);
        tick();
        req_vld = 4'b1010;
        @(negedge sys_clk); chk("wrap_rdy3", 32'(req_rdy), 32'h8);
        tick();
        req_vld = 4'b0010;
        @(negedge sys_clk); chk("wrap_rdy1", 32'(req_rdy), 32'h2);
        tick();
        drain(6);

        // Hold.
        ra[2] = 16'h8000; rb[2] = 16'h8000; req_vld = 4'b0100;
        @(negedge sys_clk); chk("hold_first_rdy", 32'(req_rdy), 32'h4);
        tick();
        hold = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge sys_clk); chk("hold_rdy", 32'(req_rdy), 32'h0);
            tick();
        end
        hold = 1'b0;
        @(negedge sys_clk);
        chk("hold_regrant", 32'(req_rdy), 32'h4);
        chk("hold_res_vld", 32'(res_vld), 32'h1);
        chk("hold_res_p", res_p, 32'h40000000);
        tick();
        drain(6);

        // Reset mid-flight.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
        end
        req_vld = 4'b0111;
        tick(); tick(); tick();
        req_vld = '0;
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge sys_clk);
            chk("rst_res_vld", 32'(res_vld), 32'h0);
            chk("rst_inflight", 32'(inflight), 32'h0);
            tick();
        end
        req_vld = 4'b0011;
        @(negedge sys_clk); chk("rst_next_rdy", 32'(req_rdy), 32'h1);
        tick();
        drain(6);

        // Extreme operands back-to-back from requester 0.
        do_reset();
        for (int n = 0; n < 8; n++) begin
            if (n < 3) begin
                ra[0] = ext_a[n]; rb[0] = ext_b[n]; req_vld = 4'b0001;
            end else begin
                req_vld = '0;
            end
            @(negedge sys_clk);
            if (n >= 4 && n < 7) chk("extreme_res_p", res_p, ext_p[n-4]);
            tick();
        end
        drain(4);

        // Randomized traffic: requests stay stable until granted.
        for (int n = 0; n < 600; n++) begin
            @(negedge sys_clk);
            g = req_vld & req_rdy;
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_vld[i] || g[i] || sys_rst) begin
                    req_vld[i] = ($urandom_range(0, 2) != 0);
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                end
            end
            hold    = ($urandom_range(0, 9) == 0);
            sys_rst = ($urandom_range(0, 99) == 0);
        end
        hold    = 1'b0;
        sys_rst = 1'b0;
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
